instr_prefetch_buffer: RTL
==========================

Name: instr_prefetch_buffer

Overview:
- Sits between the CPU instruction read port and the instruction memory.
- Streams sequential 32-bit words ahead of the PC into a small FIFO, so sequential fetches complete in zero wait cycles.
- Any out-of-stream fetch address is a redirect: the FIFO is flushed, in-flight responses are discarded, and streaming restarts at the new address.
- CPU side is an Avalon-MM read agent; memory side is a pipelined Avalon-MM read host.

Parameters:
- DEPTH, 4, FIFO entries and also the maximum reads in flight (power of two, at least 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cpu_read  in  1  CPU fetch request.
- cpu_address  in  32  fetch byte address; bits [1:0] ignored.
- cpu_waitrequest  out  1  request not served this cycle.
- cpu_readdatavalid  out  1  cpu_readdata is valid this cycle.
- cpu_readdata  out  32  instruction word.
- mem_read  out  1  memory read request.
- mem_address  out  32  word-aligned request address.
- mem_byteenable  out  4  constant 4'b1111.
- mem_waitrequest  in  1  memory stalls the request.
- mem_readdatavalid  in  1  response valid; responses return in order.
- mem_readdata  in  32  response data.
- hit_count  out  32  fetches served (see Optional Feature).
- redirect_count  out  32  redirects taken (see Optional Feature).

Behaviour:
- State: fsm {IDLE, STREAM}, FIFO (count 0..DEPTH), expect_addr, fetch_addr, outstanding (0..DEPTH), discard_cnt, stale_pending.
- Reset (async, rst=0):
  - fsm=IDLE, FIFO empty, outstanding=0, discard_cnt=0, stale_pending=0, expect_addr=0, fetch_addr=0.
  - All outputs 0, except mem_byteenable=4'b1111.
- A = {cpu_address[31:2],2'b00}.
- Hit: cpu_read && fsm==STREAM && A==expect_addr && count>0.
  - Same cycle: cpu_readdatavalid=1, cpu_waitrequest=0, cpu_readdata=FIFO head.
  - On the clock edge: pop the head, expect_addr += 4.
- Wait: cpu_read && fsm==STREAM && A==expect_addr && count==0.
  - cpu_waitrequest=1, cpu_readdatavalid=0, no state change except refill.
- Redirect: cpu_read && (fsm==IDLE || A!=expect_addr).
  - This cycle: cpu_waitrequest=1, cpu_readdatavalid=0.
  - Next cycle: fsm=STREAM, expect_addr=A, fetch_addr=A, FIFO cleared, discard_cnt = outstanding after this edge's accept/response updates.
  - A request held under mem_waitrequest at the redirect edge keeps its address and mem_read until accepted (Avalon rule). It sets stale_pending; on acceptance it increments discard_cnt and clears stale_pending.
  - The redirected address is served no earlier than 2 cycles after the redirect cycle.
- cpu_read==0: outputs deasserted (readdatavalid=0, waitrequest=0); streaming continues.
- Issue: mem_read=1 when fsm==STREAM && (stale_pending || count+outstanding<DEPTH).
  - mem_address = fetch_addr, registered and stable while mem_waitrequest=1.
  - Acceptance (mem_read && !mem_waitrequest): fetch_addr += 4 (unless stale), outstanding += 1.
  - fetch_addr wraps 0xFFFFFFFC -> 0x00000000; expect_addr wraps identically.
- Response (mem_readdatavalid): outstanding -= 1.
  - If discard_cnt>0: drop the data, discard_cnt -= 1.
  - Else: push to FIFO.
  - Acceptance and response in the same cycle leave outstanding unchanged.
- The capacity rule guarantees a push never meets a full FIFO.
- Simultaneous push and pop at any count: count unchanged. Hit with count==1 plus push: the popped word is the old head and the new word becomes head.
- Reset mid-transfer returns to IDLE. Memory responses still in flight after reset release are ignored only if they arrive while fsm==IDLE. Memory is reset together with this block.

Optional Feature:
- Macro PREFETCH_STATS_EN.
- Defined:
  - hit_count increments on each hit.
  - redirect_count increments on each redirect.
  - Both are 32-bit wrapping counters reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then cpu_read at 0x100 with memory at zero wait states -> redirect cycle; words 0x100, 0x104, 0x108 returned on consecutive cycles once filled; mem_address runs ahead to at most 0x100+4*DEPTH.
- Sequential fetch 0x100..0x10C, then jump to 0x200 with 3 reads outstanding -> 3 responses dropped; first data delivered is mem[0x200]; expect_addr=0x204 after the hit.
- Hold mem_waitrequest=1 for 5 cycles during a redirect -> mem_address and mem_read stay stable; the stale response is discarded; the correct word is delivered afterwards.
- CPU idles (cpu_read=0) for 10 cycles -> FIFO fills to DEPTH, mem_read drops to 0; next 4 sequential fetches hit in 4 consecutive cycles.
- Stream across 0xFFFFFFF8 -> words at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 delivered in order.
- With PREFETCH_STATS_EN: 6 hits and 2 redirects -> hit_count=6, redirect_count=2. Without the macro, both ports read 0.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: streams words ahead of the CPU fetch address into a small FIFO.
// Optional hit/redirect counters are built when PREFETCH_STATS_EN is defined.
module instr_prefetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic [31:0] cpu_address,
  output logic        cpu_waitrequest,
  output logic        cpu_readdatavalid,
  output logic [31:0] cpu_readdata,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [31:0] mem_readdata,
  output logic [31:0] hit_count,
  output logic [31:0] redirect_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fifo [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count, r_outstanding, r_discard_cnt;
  logic            r_stale_pending;
  logic [31:0]     r_stale_addr, r_expect_addr, r_fetch_addr;

  logic [31:0]     w_addr;
  logic            w_hit, w_wait, w_redirect;
  logic            w_room, w_accept, w_resp, w_drop, w_push;
  logic [CW-1:0]   w_out_nxt;
  logic            w_unused_addr_lsb;

  assign w_addr            = {cpu_address[31:2], 2'b00};
  assign w_unused_addr_lsb = ^cpu_address[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_wait      = 1'b0;
    w_redirect  = 1'b0;
    if (cpu_read) begin
      if (r_state == IDLE || w_addr != r_expect_addr) begin
        w_redirect  = 1'b1;
        w_state_nxt = STREAM;
      end else if (r_count != '0) begin
        w_hit = 1'b1;
      end else begin
        w_wait = 1'b1;
      end
    end
  end

  assign cpu_waitrequest   = w_redirect | w_wait;
  assign cpu_readdatavalid = w_hit;
  assign cpu_readdata      = w_hit ? r_fifo[r_rd_ptr] : '0;

  // Buffered plus in-flight words never exceed DEPTH, so a push always finds room.
  assign w_room      = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
  assign mem_read    = (r_state == STREAM) && (r_stale_pending || w_room);
  assign mem_address = r_stale_pending ? r_stale_addr : r_fetch_addr;
  assign mem_byteenable = 4'b1111;

  assign w_accept  = mem_read && !mem_waitrequest;
  assign w_resp    = mem_readdatavalid && (r_state == STREAM);
  assign w_drop    = w_resp && (r_discard_cnt != '0);
  assign w_push    = w_resp && !w_drop;
  assign w_out_nxt = r_outstanding + CW'(w_accept) - CW'(w_resp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_outstanding   <= '0;
      r_discard_cnt   <= '0;
      r_stale_pending <= 1'b0;
      r_stale_addr    <= '0;
      r_expect_addr   <= '0;
      r_fetch_addr    <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_redirect) begin
        r_expect_addr   <= w_addr;
        r_fetch_addr    <= w_addr;
        r_rd_ptr        <= '0;
        r_wr_ptr        <= '0;
        r_count         <= '0;
        r_discard_cnt   <= w_out_nxt;
        // A request stuck under waitrequest must still complete; its data is junk.
        r_stale_pending <= mem_read && mem_waitrequest;
        r_stale_addr    <= mem_address;
      end else begin
        if (w_hit) begin
          r_expect_addr <= r_expect_addr + 32'd4;
          r_rd_ptr      <= r_rd_ptr + AW'(1);
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_hit);
        if (w_accept) begin
          if (r_stale_pending) r_stale_pending <= 1'b0;
          else                 r_fetch_addr    <= r_fetch_addr + 32'd4;
        end
        r_discard_cnt <= r_discard_cnt - CW'(w_drop) + CW'(w_accept && r_stale_pending);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_redirect) r_fifo[r_wr_ptr] <= mem_readdata;
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] r_hit_count, r_redirect_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count      <= '0;
      r_redirect_count <= '0;
    end else begin
      r_hit_count      <= r_hit_count + 32'(w_hit);
      r_redirect_count <= r_redirect_count + 32'(w_redirect);
    end
  end

  assign hit_count      = r_hit_count;
  assign redirect_count = r_redirect_count;
`else
  assign hit_count      = '0;
  assign redirect_count = '0;
`endif

endmodule
